ex_stage_unit: RTL and testbench
================================

Name: ex_stage_unit

Overview:
Consumer end of the 222-bit ID/EX bundle. Unpacks the bundle and forwards rs1/rs2 operands. Resolves branches, JAL and JALR. Detects load-use hazards and drives the enable/Flush inputs of the ID/EX and IF/ID registers. Registers a packed 109-bit EX/MEM bundle. The ALU itself is external: this block presents operands and captures the result.

Parameters:
XLEN, 32, datapath width; all 32-bit fields below equal XLEN.
IDEX_W, 222, ID/EX bundle width.
EXMEM_W, 109, EX/MEM bundle width.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
enable  in  1  downstream advance; 0 holds the EX/MEM register
flush_in  in  1  zeroes the EX/MEM register on the next edge
DataOut_ID_EX  in  222  ID/EX bundle, LSB first: imm[31:0], Rd1[63:32], Rd2[95:64], RD[100:96], ALUOp[103:101], RegWrite104, MemToReg105, MemWrite106, MemRead107, Jal108, Jalr109, Branch110, AluSrc111, func3[114:112], func7 115, pc_in[147:116], Rs1[152:148], Rs2[157:153], PC[189:158], PCplus4[221:190]
if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID
memwb_regwrite  in  1;  memwb_rd  in  5;  memwb_result  in  32  writeback bypass
alu_a, alu_b  out  32 each  ALU operands; alu_op out 3, alu_func3 out 3, alu_func7 out 1
alu_result  in  32  combinational result from the external ALU
stall  out  1  hold PC and IF/ID; also drives ID/EX Flush (bubble)
redirect  out  1  control transfer taken
redirect_pc  out  32  new PC
flush_front  out  1  flush IF/ID and ID/EX
DataOut_EX_MEM  out  109  alu_result[31:0], store_data[63:32], rd[68:64], RegWrite69, MemToReg70, MemWrite71, MemRead72, link73, func3[76:74], PCplus4[108:77]

Behaviour:
- Reset: DataOut_EX_MEM = 0 on the first edge with reset=1. All combinational outputs follow the zeroed state and inputs.
- EX/MEM register priority: reset > flush_in > enable=1 (capture) > hold.
- Bubble: an all-zero ID/EX bundle produces no writes, no redirect and no stall.
- Forwarding of rs1 and rs2, per operand:
  - Field equals 0: use the bundle Rd1/Rd2 value.
  - Else if EX/MEM RegWrite=1, MemRead=0 and rd matches: use link ? PCplus4 : alu_result, taken from the registered EX/MEM bundle.
  - Else if memwb_regwrite=1 and memwb_rd matches: use memwb_result.
  - Else: use the bundle value.
  - EX/MEM has priority over MEM/WB.
- Operands:
  - alu_a = fwd_rs1.
  - alu_b = AluSrc ? imm : fwd_rs2.
  - store_data = fwd_rs2.
- Branch compare on fwd_rs1 vs fwd_rs2, selected by func3:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010/011 are never taken.
- Redirect:
  - redirect = enable & (Jal | Jalr | (Branch & taken)).
  - redirect_pc = Jalr ? ((fwd_rs1 + imm) & ~1) : (PC + imm), modulo 2^32 with wrap-around.
  - The pc_in field is not used.
  - flush_front = redirect.
- Load-use: stall = MemRead & (RD≠0) & (RD==if_id_rs1 | RD==if_id_rs2) & ~redirect.
  - Redirect wins because the ID instruction is discarded.
  - Exactly one stall cycle per hazard: the bubble inserted next cycle clears MemRead.
- link = Jal | Jalr, so MEM/WB writes PCplus4.
- The instruction in EX always completes; redirect flushes only younger stages.
- Latency: 1 cycle from ID/EX to EX/MEM. All hazard and redirect outputs are combinational in the same cycle.
- Reset mid-operation: the register clears and outputs follow the inputs. Holding enable=0 keeps redirect low and holds the register.

Decomposition:
- Package ex_pkg: field LSB/MSB constants for both bundles, func3 branch encodings, widths.
- Sub-module branch_cmp: fwd_rs1, fwd_rs2, func3 -> taken.

Test Plan:
- reset=1 for 2 edges with a nonzero bundle -> DataOut_EX_MEM=0, redirect=0, stall=0.
- ADD x5 with Rd1=3, Rd2=4, alu_result=7, then the next bundle has Rs1=5 -> alu_a=7 (EX/MEM bypass). Also memwb_rd=5 with memwb_result=9 at the same time -> alu_a still 7.
- BEQ, PC=0x100, imm=0x20, rs1 and rs2 both 0x55 -> redirect=1, redirect_pc=0x120, flush_front=1. Same with func3=001 -> redirect=0.
- JALR with fwd_rs1=0x1001, imm=4 -> redirect_pc=0x1004. Captured DataOut_EX_MEM has link=1 and PCplus4 passed through.
- LW with RD=6 in EX, if_id_rs2=6 -> stall=1 for one cycle. Bubble next cycle -> stall=0, then MEM/WB forwards the load value. RD=0 gives no stall.
- enable=0 with flush_in=1 -> register zeroes. enable=0 alone -> hold, redirect=0. PC=0xFFFFFFF0, imm=0x20 -> redirect_pc=0x10.

Source files
------------

// File: rtl/ex_pkg.sv
// Field positions, widths and branch encodings shared by the EX stage.
package ex_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IDEX_W  = 222;
  localparam int unsigned EXMEM_W = 109;
  localparam int unsigned REG_W   = 5;

  // ID/EX bundle fields
  localparam int unsigned ID_IMM_LSB   = 0;
  localparam int unsigned ID_IMM_MSB   = 31;
  localparam int unsigned ID_RD1_LSB   = 32;
  localparam int unsigned ID_RD1_MSB   = 63;
  localparam int unsigned ID_RD2_LSB   = 64;
  localparam int unsigned ID_RD2_MSB   = 95;
  localparam int unsigned ID_RD_LSB    = 96;
  localparam int unsigned ID_RD_MSB    = 100;
  localparam int unsigned ID_ALUOP_LSB = 101;
  localparam int unsigned ID_ALUOP_MSB = 103;
  localparam int unsigned ID_REGWRITE  = 104;
  localparam int unsigned ID_MEMTOREG  = 105;
  localparam int unsigned ID_MEMWRITE  = 106;
  localparam int unsigned ID_MEMREAD   = 107;
  localparam int unsigned ID_JAL       = 108;
  localparam int unsigned ID_JALR      = 109;
  localparam int unsigned ID_BRANCH    = 110;
  localparam int unsigned ID_ALUSRC    = 111;
  localparam int unsigned ID_FUNC3_LSB = 112;
  localparam int unsigned ID_FUNC3_MSB = 114;
  localparam int unsigned ID_FUNC7     = 115;
  localparam int unsigned ID_PCIN_LSB  = 116;
  localparam int unsigned ID_PCIN_MSB  = 147;
  localparam int unsigned ID_RS1_LSB   = 148;
  localparam int unsigned ID_RS1_MSB   = 152;
  localparam int unsigned ID_RS2_LSB   = 153;
  localparam int unsigned ID_RS2_MSB   = 157;
  localparam int unsigned ID_PC_LSB    = 158;
  localparam int unsigned ID_PC_MSB    = 189;
  localparam int unsigned ID_PC4_LSB   = 190;
  localparam int unsigned ID_PC4_MSB   = 221;

  // EX/MEM bundle fields
  localparam int unsigned EM_ALU_LSB   = 0;
  localparam int unsigned EM_ALU_MSB   = 31;
  localparam int unsigned EM_STORE_LSB = 32;
  localparam int unsigned EM_STORE_MSB = 63;
  localparam int unsigned EM_RD_LSB    = 64;
  localparam int unsigned EM_RD_MSB    = 68;
  localparam int unsigned EM_REGWRITE  = 69;
  localparam int unsigned EM_MEMTOREG  = 70;
  localparam int unsigned EM_MEMWRITE  = 71;
  localparam int unsigned EM_MEMREAD   = 72;
  localparam int unsigned EM_LINK      = 73;
  localparam int unsigned EM_FUNC3_LSB = 74;
  localparam int unsigned EM_FUNC3_MSB = 76;
  localparam int unsigned EM_PC4_LSB   = 77;
  localparam int unsigned EM_PC4_MSB   = 108;

  // Branch condition encodings carried in func3
  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_func3_e;

endpackage

// File: rtl/ex_stage_unit_branch_cmp.sv
// Branch condition evaluation on the forwarded operands.
module branch_cmp
  import ex_pkg::*;
(
  input  logic [XLEN-1:0] fwd_rs1,
  input  logic [XLEN-1:0] fwd_rs2,
  input  logic [2:0]      func3,
  output logic            taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (fwd_rs1 == fwd_rs2);
  assign lt_s = ($signed(fwd_rs1) < $signed(fwd_rs2));
  assign lt_u = (fwd_rs1 < fwd_rs2);

  // Select the condition; reserved encodings never take
  always_comb begin
    taken = 1'b0;
    case (br_func3_e'(func3))
      BR_EQ:   taken = eq;
      BR_NE:   taken = ~eq;
      BR_LT:   taken = lt_s;
      BR_GE:   taken = ~lt_s;
      BR_LTU:  taken = lt_u;
      BR_GEU:  taken = ~lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_stage_unit.sv
// EX stage: unpacks ID/EX, forwards operands, resolves control transfers,
// detects load-use hazards and registers the EX/MEM bundle.
module ex_stage_unit
  import ex_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                flush_in,
  input  logic [IDEX_W-1:0]   DataOut_ID_EX,
  input  logic [REG_W-1:0]    if_id_rs1,
  input  logic [REG_W-1:0]    if_id_rs2,
  input  logic                memwb_regwrite,
  input  logic [REG_W-1:0]    memwb_rd,
  input  logic [XLEN-1:0]     memwb_result,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  output logic [2:0]          alu_op,
  output logic [2:0]          alu_func3,
  output logic                alu_func7,
  input  logic [XLEN-1:0]     alu_result,
  output logic                stall,
  output logic                redirect,
  output logic [XLEN-1:0]     redirect_pc,
  output logic                flush_front,
  output logic [EXMEM_W-1:0]  DataOut_EX_MEM
);

  // ID/EX fields
  logic [XLEN-1:0]  id_imm;
  logic [XLEN-1:0]  id_rd1;
  logic [XLEN-1:0]  id_rd2;
  logic [REG_W-1:0] id_rd;
  logic [2:0]       id_aluop;
  logic             id_regwrite;
  logic             id_memtoreg;
  logic             id_memwrite;
  logic             id_memread;
  logic             id_jal;
  logic             id_jalr;
  logic             id_branch;
  logic             id_alusrc;
  logic [2:0]       id_func3;
  logic             id_func7;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_pc4;
  logic             unused_pc_in;

  assign id_imm      = DataOut_ID_EX[ID_IMM_MSB:ID_IMM_LSB];
  assign id_rd1      = DataOut_ID_EX[ID_RD1_MSB:ID_RD1_LSB];
  assign id_rd2      = DataOut_ID_EX[ID_RD2_MSB:ID_RD2_LSB];
  assign id_rd       = DataOut_ID_EX[ID_RD_MSB:ID_RD_LSB];
  assign id_aluop    = DataOut_ID_EX[ID_ALUOP_MSB:ID_ALUOP_LSB];
  assign id_regwrite = DataOut_ID_EX[ID_REGWRITE];
  assign id_memtoreg = DataOut_ID_EX[ID_MEMTOREG];
  assign id_memwrite = DataOut_ID_EX[ID_MEMWRITE];
  assign id_memread  = DataOut_ID_EX[ID_MEMREAD];
  assign id_jal      = DataOut_ID_EX[ID_JAL];
  assign id_jalr     = DataOut_ID_EX[ID_JALR];
  assign id_branch   = DataOut_ID_EX[ID_BRANCH];
  assign id_alusrc   = DataOut_ID_EX[ID_ALUSRC];
  assign id_func3    = DataOut_ID_EX[ID_FUNC3_MSB:ID_FUNC3_LSB];
  assign id_func7    = DataOut_ID_EX[ID_FUNC7];
  assign id_rs1      = DataOut_ID_EX[ID_RS1_MSB:ID_RS1_LSB];
  assign id_rs2      = DataOut_ID_EX[ID_RS2_MSB:ID_RS2_LSB];
  assign id_pc       = DataOut_ID_EX[ID_PC_MSB:ID_PC_LSB];
  assign id_pc4      = DataOut_ID_EX[ID_PC4_MSB:ID_PC4_LSB];
  // pc_in is carried by the bundle but targets are formed from PC
  assign unused_pc_in = ^DataOut_ID_EX[ID_PCIN_MSB:ID_PCIN_LSB];

  // Registered EX/MEM state
  logic [EXMEM_W-1:0] ex_mem_q;
  logic [EXMEM_W-1:0] ex_mem_d;
  logic [XLEN-1:0]    em_alu;
  logic [REG_W-1:0]   em_rd;
  logic               em_regwrite;
  logic               em_memread;
  logic               em_link;
  logic [XLEN-1:0]    em_pc4;
  logic               em_fwd_ok;
  logic [XLEN-1:0]    em_fwd_val;

  assign em_alu      = ex_mem_q[EM_ALU_MSB:EM_ALU_LSB];
  assign em_rd       = ex_mem_q[EM_RD_MSB:EM_RD_LSB];
  assign em_regwrite = ex_mem_q[EM_REGWRITE];
  assign em_memread  = ex_mem_q[EM_MEMREAD];
  assign em_link     = ex_mem_q[EM_LINK];
  assign em_pc4      = ex_mem_q[EM_PC4_MSB:EM_PC4_LSB];
  // Load data is not available yet in EX/MEM, so loads never bypass from there
  assign em_fwd_ok   = em_regwrite & ~em_memread;
  assign em_fwd_val  = em_link ? em_pc4 : em_alu;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // rs1 bypass: EX/MEM beats MEM/WB, x0 never bypasses
  always_comb begin
    fwd_rs1 = id_rd1;
    if (id_rs1 != '0) begin
      if (em_fwd_ok && (em_rd == id_rs1)) begin
        fwd_rs1 = em_fwd_val;
      end else if (memwb_regwrite && (memwb_rd == id_rs1)) begin
        fwd_rs1 = memwb_result;
      end
    end
  end

  // rs2 bypass: same priority as rs1
  always_comb begin
    fwd_rs2 = id_rd2;
    if (id_rs2 != '0) begin
      if (em_fwd_ok && (em_rd == id_rs2)) begin
        fwd_rs2 = em_fwd_val;
      end else if (memwb_regwrite && (memwb_rd == id_rs2)) begin
        fwd_rs2 = memwb_result;
      end
    end
  end

  assign alu_a     = fwd_rs1;
  assign alu_b     = id_alusrc ? id_imm : fwd_rs2;
  assign alu_op    = id_aluop;
  assign alu_func3 = id_func3;
  assign alu_func7 = id_func7;

  logic            br_taken;
  logic [XLEN-1:0] jalr_sum;

  branch_cmp u_branch_cmp (
    .fwd_rs1 (fwd_rs1),
    .fwd_rs2 (fwd_rs2),
    .func3   (id_func3),
    .taken   (br_taken)
  );

  assign jalr_sum    = fwd_rs1 + id_imm;
  assign redirect    = enable & (id_jal | id_jalr | (id_branch & br_taken));
  assign redirect_pc = id_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (id_pc + id_imm);
  assign flush_front = redirect;

  // A redirect discards the ID instruction, so it cannot be hazarded on
  assign stall = id_memread & (id_rd != '0) &
                 ((id_rd == if_id_rs1) | (id_rd == if_id_rs2)) & ~redirect;

  // Assemble the next EX/MEM bundle
  always_comb begin
    ex_mem_d = '0;
    ex_mem_d[EM_ALU_MSB:EM_ALU_LSB]     = alu_result;
    ex_mem_d[EM_STORE_MSB:EM_STORE_LSB] = fwd_rs2;
    ex_mem_d[EM_RD_MSB:EM_RD_LSB]       = id_rd;
    ex_mem_d[EM_REGWRITE]               = id_regwrite;
    ex_mem_d[EM_MEMTOREG]               = id_memtoreg;
    ex_mem_d[EM_MEMWRITE]               = id_memwrite;
    ex_mem_d[EM_MEMREAD]                = id_memread;
    ex_mem_d[EM_LINK]                   = id_jal | id_jalr;
    ex_mem_d[EM_FUNC3_MSB:EM_FUNC3_LSB] = id_func3;
    ex_mem_d[EM_PC4_MSB:EM_PC4_LSB]     = id_pc4;
  end

  // EX/MEM register: reset > flush > capture > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_q <= '0;
    end else if (flush_in) begin
      ex_mem_q <= '0;
    end else if (enable) begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign DataOut_EX_MEM = ex_mem_q;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Directed bench for ex_stage_unit with a field-level reference model.
module tb_ex_stage_unit;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         flush_in;
  logic [221:0] DataOut_ID_EX;
  logic [4:0]   if_id_rs1;
  logic [4:0]   if_id_rs2;
  logic         memwb_regwrite;
  logic [4:0]   memwb_rd;
  logic [31:0]  memwb_result;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [2:0]   alu_op;
  logic [2:0]   alu_func3;
  logic         alu_func7;
  logic [31:0]  alu_result;
  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         flush_front;
  logic [108:0] DataOut_EX_MEM;

  ex_stage_unit dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .flush_in       (flush_in),
    .DataOut_ID_EX  (DataOut_ID_EX),
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .alu_func3      (alu_func3),
    .alu_func7      (alu_func7),
    .alu_result     (alu_result),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush_front    (flush_front),
    .DataOut_EX_MEM (DataOut_EX_MEM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm, rd1, rd2, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  aluop, f3;
    logic        f7, rw, m2r, mw, mr, jal, jalr, br, asrc;
  } instr_t;

  typedef struct {
    logic [31:0] alu, store, pc4;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw, m2r, mw, mr, link;
  } mem_t;

  instr_t cur;
  instr_t t;
  mem_t   m;
  int     n_pass = 0;
  int     n_total = 0;
  bit     chk_en = 1'b0;

  task automatic chk(input string name, input logic [108:0] act, input logic [108:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [221:0] pack(input instr_t i);
    logic [221:0] b;
    b = '0;
    b[31:0] = i.imm;     b[63:32] = i.rd1;     b[95:64] = i.rd2;
    b[100:96] = i.rd;    b[103:101] = i.aluop;
    b[104] = i.rw;  b[105] = i.m2r; b[106] = i.mw;  b[107] = i.mr;
    b[108] = i.jal; b[109] = i.jalr; b[110] = i.br; b[111] = i.asrc;
    b[114:112] = i.f3;   b[115] = i.f7;
    b[147:116] = 32'hDEAD_BEEF;
    b[152:148] = i.rs1;  b[157:153] = i.rs2;
    b[189:158] = i.pc;   b[221:190] = i.pc4;
    return b;
  endfunction

  function automatic logic [108:0] mem_bits(input mem_t x);
    logic [108:0] b;
    b = '0;
    b[31:0] = x.alu; b[63:32] = x.store; b[68:64] = x.rd;
    b[69] = x.rw; b[70] = x.m2r; b[71] = x.mw; b[72] = x.mr; b[73] = x.link;
    b[76:74] = x.f3; b[108:77] = x.pc4;
    return b;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] v);
    if (rs == 5'd0) return v;
    if (m.rw && !m.mr && m.rd == rs) return m.link ? m.pc4 : m.alu;
    if (memwb_regwrite && memwb_rd == rs) return memwb_result;
    return v;
  endfunction

  function automatic logic taken(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Model of the EX/MEM register
  initial begin
    m = '{default: '0};
    forever begin
      @(posedge clk);
      if (reset || flush_in) begin
        m <= '{default: '0};
      end else if (enable) begin
        m.alu   <= alu_result;
        m.store <= fwd(cur.rs2, cur.rd2);
        m.pc4   <= cur.pc4;
        m.rd    <= cur.rd;
        m.f3    <= cur.f3;
        m.rw    <= cur.rw;
        m.m2r   <= cur.m2r;
        m.mw    <= cur.mw;
        m.mr    <= cur.mr;
        m.link  <= cur.jal | cur.jalr;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    logic [31:0] e_a, e_r2, e_pc;
    logic        e_red, e_stall;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_a   = fwd(cur.rs1, cur.rd1);
        e_r2  = fwd(cur.rs2, cur.rd2);
        e_red = enable & (cur.jal | cur.jalr | (cur.br & taken(e_a, e_r2, cur.f3)));
        e_pc  = cur.jalr ? ((e_a + cur.imm) & ~32'd1) : (cur.pc + cur.imm);
        e_stall = cur.mr && (cur.rd != 5'd0) &&
                  (cur.rd == if_id_rs1 || cur.rd == if_id_rs2) && !e_red;
        chk("m_exmem", DataOut_EX_MEM, mem_bits(m));
        chk("m_alu_a", alu_a, e_a);
        chk("m_alu_b", alu_b, cur.asrc ? cur.imm : e_r2);
        chk("m_alu_op", alu_op, cur.aluop);
        chk("m_func3", alu_func3, cur.f3);
        chk("m_func7", alu_func7, cur.f7);
        chk("m_redirect", redirect, e_red);
        chk("m_redirect_pc", redirect_pc, e_pc);
        chk("m_flush_front", flush_front, e_red);
        chk("m_stall", stall, e_stall);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input instr_t i, input logic [31:0] ar);
    cur = i;
    cur.pc4 = i.pc + 32'd4;
    DataOut_ID_EX = pack(cur);
    alu_result = ar;
  endtask

  task automatic bubble();
    cur = '{default: '0};
    DataOut_ID_EX = '0;
    alu_result = '0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; flush_in = 1'b0;
    if_id_rs1 = '0; if_id_rs2 = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;

    // ADD x5 = x1 + x2 presented during reset
    t = '{rs1: 5'd1, rs2: 5'd2, rd1: 32'd3, rd2: 32'd4, rd: 5'd5, rw: 1'b1, pc: 32'h40, default: '0};
    issue(t, 32'd7);
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_exmem", DataOut_EX_MEM, '0);
    chk("rst_redirect", redirect, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("add_alu_a", alu_a, 32'd3);
    reset = 1'b0;

    // EX/MEM bypass beats MEM/WB
    tick();
    t = '{rs1: 5'd5, rd1: 32'h111, rd: 5'd7, rw: 1'b1, pc: 32'h44, default: '0};
    issue(t, 32'd7);
    memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_result = 32'd9;
    @(negedge clk);
    chk("exmem_fwd_a", alu_a, 32'd7);
    chk("exmem_alu", DataOut_EX_MEM[31:0], 32'd7);
    chk("exmem_rd", DataOut_EX_MEM[68:64], 5'd5);

    // rs1 from MEM/WB, rs2 from EX/MEM
    tick();
    t = '{rs1: 5'd5, rs2: 5'd7, rd1: 32'h222, rd2: 32'h333, rd: 5'd8, rw: 1'b1, pc: 32'h48, default: '0};
    issue(t, 32'h10);
    @(negedge clk);
    chk("memwb_fwd_a", alu_a, 32'd9);
    chk("exmem_fwd_b", alu_b, 32'd7);

    // BEQ taken, then BNE not taken
    tick();
    memwb_regwrite = 1'b0;
    t = '{rs1: 5'd1, rs2: 5'd2, rd1: 32'h55, rd2: 32'h55, br: 1'b1, f3: 3'd0,
          pc: 32'h100, imm: 32'h20, default: '0};
    issue(t, 32'd0);
    @(negedge clk);
    chk("beq_redirect", redirect, 1'b1);
    chk("beq_pc", redirect_pc, 32'h120);
    chk("beq_flush", flush_front, 1'b1);
    tick();
    t.f3 = 3'd1;
    issue(t, 32'd0);
    @(negedge clk);
    chk("bne_redirect", redirect, 1'b0);

    // All func3 codes on signed/unsigned-sensitive and equal operand pairs
    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < 8; f++) begin
        tick();
        t = '{rs1: 5'd1, rs2: 5'd2, br: 1'b1, pc: 32'h300, imm: 32'hFFFF_FFF8, default: '0};
        t.f3  = 3'(f);
        t.rd1 = (p == 0) ? 32'h8000_0000 : 32'h1234;
        t.rd2 = (p == 0) ? 32'd5 : 32'h1234;
        issue(t, 32'd0);
      end
    end

    // JALR target clears bit 0
    tick();
    t = '{rs1: 5'd3, rd1: 32'h1001, imm: 32'd4, jalr: 1'b1, rw: 1'b1, rd: 5'd1,
          pc: 32'h200, default: '0};
    issue(t, 32'h999);
    @(negedge clk);
    chk("jalr_pc", redirect_pc, 32'h1004);
    chk("jalr_redirect", redirect, 1'b1);

    // Link value forwarded from EX/MEM
    tick();
    t = '{rs1: 5'd1, rd: 5'd9, rw: 1'b1, asrc: 1'b1, imm: 32'h10, pc: 32'h204, default: '0};
    issue(t, 32'd0);
    @(negedge clk);
    chk("jalr_link", DataOut_EX_MEM[73], 1'b1);
    chk("jalr_pc4", DataOut_EX_MEM[108:77], 32'h204);
    chk("link_fwd_a", alu_a, 32'h204);
    chk("imm_b", alu_b, 32'h10);

    // Load-use: one stall, bubble, then MEM/WB supplies the load value
    tick();
    t = '{rs1: 5'd2, rd1: 32'h1000, imm: 32'd8, asrc: 1'b1, mr: 1'b1, rw: 1'b1,
          m2r: 1'b1, rd: 5'd6, f3: 3'd2, pc: 32'h400, default: '0};
    issue(t, 32'h1008);
    if_id_rs1 = 5'd3; if_id_rs2 = 5'd6;
    @(negedge clk);
    chk("lu_stall", stall, 1'b1);
    tick();
    bubble();
    @(negedge clk);
    chk("lu_bubble", stall, 1'b0);
    tick();
    t = '{rs2: 5'd6, rd: 5'd10, rw: 1'b1, pc: 32'h404, default: '0};
    issue(t, 32'd0);
    memwb_regwrite = 1'b1; memwb_rd = 5'd6; memwb_result = 32'hCAFE;
    @(negedge clk);
    chk("lu_fwd_b", alu_b, 32'hCAFE);
    tick();
    memwb_regwrite = 1'b0;
    t = '{mr: 1'b1, rw: 1'b1, rd: 5'd0, pc: 32'h408, default: '0};
    issue(t, 32'd0);
    if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
    @(negedge clk);
    chk("ld_x0_nostall", stall, 1'b0);

    // Flush with enable low zeroes the register
    tick();
    t = '{rd: 5'd11, rw: 1'b1, pc: 32'h40C, default: '0};
    issue(t, 32'h77);
    tick();
    t = '{jal: 1'b1, rd: 5'd1, rw: 1'b1, pc: 32'h500, imm: 32'h40, default: '0};
    issue(t, 32'd0);
    enable = 1'b0; flush_in = 1'b1;
    @(negedge clk);
    chk("dis_redirect", redirect, 1'b0);
    chk("pre_flush_alu", DataOut_EX_MEM[31:0], 32'h77);
    tick();
    @(negedge clk);
    chk("flush_exmem", DataOut_EX_MEM, '0);

    // Capture a JAL, then hold it with enable low
    flush_in = 1'b0; enable = 1'b1;
    tick();
    enable = 1'b0;
    t = '{jal: 1'b1, rd: 5'd2, rw: 1'b1, pc: 32'h600, imm: 32'h8, default: '0};
    issue(t, 32'h3);
    tick();
    tick();
    @(negedge clk);
    chk("hold_redirect", redirect, 1'b0);
    chk("hold_pc4", DataOut_EX_MEM[108:77], 32'h504);
    chk("hold_link", DataOut_EX_MEM[73], 1'b1);

    // Target wraps modulo 2^32
    enable = 1'b1;
    t = '{jal: 1'b1, rd: 5'd1, rw: 1'b1, pc: 32'hFFFF_FFF0, imm: 32'h20, default: '0};
    issue(t, 32'd0);
    @(negedge clk);
    chk("wrap_pc", redirect_pc, 32'h10);
    chk("wrap_redirect", redirect, 1'b1);

    // Reset mid-operation
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_exmem", DataOut_EX_MEM, '0);
    reset = 1'b0;
    bubble();
    tick();
    tick();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
